// File: rtl/time_keeper_pkg.sv
// time_keeper shared types: heartbeat FSM states,
// time-width helper and beat-select constants.
package time_keeper_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } hb_state_t;

  localparam logic BEAT_LO = 1'b0;
  localparam logic BEAT_HI = 1'b1;

  function automatic int ntime(input int hi, input int lo);
    return hi + lo;
  endfunction

endpackage

// File: rtl/time_keeper_tick.sv
// unit_tick_gen: divides clk into time units of unit_len
// cycles and emits a registered one-cycle unit_pulse.
module unit_tick_gen #(
  parameter int NUNIT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NUNIT-1:0] unit_len,
  input  logic             restart,
  input  logic             pause,
  output logic             unit_pulse
);

  logic [NUNIT-1:0] cnt;
  logic             wrap;

  // A lowered unit_len that is already behind cnt wraps at once.
  assign wrap = (unit_len != '0) &&
                (cnt >= unit_len - NUNIT'(1));

  // Unit counter and pulse register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      unit_pulse <= 1'b0;
    end else if (restart) begin
      cnt        <= '0;
      unit_pulse <= 1'b0;
    end else if (pause) begin
      unit_pulse <= 1'b0;
    end else if (unit_len == '0) begin
      cnt        <= '0;
      unit_pulse <= 1'b0;
    end else if (wrap) begin
      cnt        <= '0;
      unit_pulse <= 1'b1;
    end else begin
      cnt        <= cnt + NUNIT'(1);
      unit_pulse <= 1'b0;
    end
  end

endmodule

// File: rtl/time_keeper.sv
// time_keeper: wall clock, per-channel stall, heartbeats.
// Optional pause input enabled by TIME_KEEPER_PAUSE_EN.
module time_keeper
  import time_keeper_pkg::*;
#(
  parameter int NUNIT    = 16,
  parameter int NTIME_HI = 20,
  parameter int NTIME_LO = 20,
  parameter int NCHAN    = 2,
  parameter int NDROP    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUNIT-1:0]       unit_len,
  input  logic                   reset_time,
  input  logic [NCHAN-1:0][NTIME_HI+NTIME_LO-1:0] pc_time,
  input  logic [NTIME_LO-1:0]    hb_period,
`ifdef TIME_KEEPER_PAUSE_EN
  input  logic                   pause,
`endif
  output logic                   unit_pulse,
  output logic [NTIME_HI+NTIME_LO-1:0] time_elapsed,
  output logic [NCHAN-1:0]       stall_dn,
  output logic [NTIME_LO-1:0]    hb_data,
  output logic                   hb_last,
  output logic                   hb_valid,
  input  logic                   hb_ready,
  output logic [NDROP-1:0]       hb_drop_cnt
);

  localparam int NTIME = ntime(NTIME_HI, NTIME_LO);

  logic              pause_i;
  logic [NTIME-1:0]  snap;
  logic [NTIME_LO-1:0] pcnt;
  logic [NTIME_LO-1:0] pcnt_inc;
  logic              trig;
  hb_state_t         state, state_n;
  logic [NTIME-1:0]  cur;
  logic [NTIME-1:0]  pend;
  logic              pend_v;
  logic              pend_ok;
  logic              acc;
  logic              take_pend;
  logic              trig_direct;
  logic              trig_pend;

`ifdef TIME_KEEPER_PAUSE_EN
  assign pause_i = pause;
`else
  assign pause_i = 1'b0;
`endif

  unit_tick_gen #(.NUNIT(NUNIT)) u_tick (
    .clk        (clk),
    .reset      (reset),
    .unit_len   (unit_len),
    .restart    (reset_time),
    .pause      (pause_i),
    .unit_pulse (unit_pulse)
  );

  assign snap     = time_elapsed + NTIME'(1);
  assign pcnt_inc = pcnt + NTIME_LO'(1);
  assign trig     = unit_pulse && !reset_time &&
                    (hb_period != '0) &&
                    (pcnt_inc >= hb_period);

  // Wall time: restart wins over a coincident unit pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      time_elapsed <= NTIME'(1);
    else if (reset_time)
      time_elapsed <= NTIME'(1);
    else if (unit_pulse)
      time_elapsed <= snap;
  end

  // Heartbeat period counter, counts units up to hb_period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pcnt <= '0;
    else if (reset_time || hb_period == '0)
      pcnt <= '0;
    else if (unit_pulse)
      pcnt <= trig ? '0 : pcnt_inc;
  end

  // Per-channel stall: stream waits until wall time catches up.
  for (genvar i = 0; i < NCHAN; i++) begin : g_stall
    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        stall_dn[i] <= 1'b0;
      else
        stall_dn[i] <= pc_time[i] > time_elapsed;
    end
  end

  assign acc         = hb_valid && hb_ready;
  assign pend_ok     = pend_v && !reset_time;
  assign take_pend   = (state == HI) && acc && pend_ok;
  assign trig_direct = trig && ((state == IDLE) ||
                       ((state == HI) && acc && !pend_ok));
  assign trig_pend   = trig && !trig_direct;

  // Heartbeat FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  // Heartbeat next state and beat outputs.
  always_comb begin
    state_n  = state;
    hb_valid = 1'b0;
    hb_last  = 1'b0;
    hb_data  = '0;
    unique case (state)
      IDLE: begin
        if (trig)
          state_n = LO;
      end
      LO: begin
        hb_valid = 1'b1;
        hb_last  = BEAT_LO;
        hb_data  = cur[NTIME_LO-1:0];
        if (acc)
          state_n = HI;
      end
      HI: begin
        hb_valid = 1'b1;
        hb_last  = BEAT_HI;
        hb_data  = NTIME_LO'(cur[NTIME-1:NTIME_LO]);
        if (acc)
          state_n = (pend_ok || trig) ? LO : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Snapshot in flight and the one-deep pending slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur         <= '0;
      pend        <= '0;
      pend_v      <= 1'b0;
      hb_drop_cnt <= '0;
    end else begin
      if (trig_direct)
        cur <= snap;
      else if (take_pend)
        cur <= pend;
      if (reset_time) begin
        pend_v <= 1'b0;
      end else if (trig_pend) begin
        pend   <= snap;
        pend_v <= 1'b1;
        if (pend_v && !take_pend && hb_drop_cnt != '1)
          hb_drop_cnt <= hb_drop_cnt + NDROP'(1);
      end else if (take_pend) begin
        pend_v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper: random stimulus against a queue-based
// reference of units, stalls and heartbeat transactions.
module tb_time_keeper;

  localparam int NUNIT = 8;
  localparam int NHI   = 4;
  localparam int NLO   = 6;
  localparam int NT    = NHI + NLO;
  localparam int TMASK = (1 << NT) - 1;
  localparam int LMASK = (1 << NLO) - 1;
  localparam int DMAX  = 3;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [NUNIT-1:0]       unit_len = '0;
  logic                   reset_time = 1'b0;
  logic [1:0][NT-1:0]     pc_time = '0;
  logic [NLO-1:0]         hb_period = '0;
  logic                   pause = 1'b0;
  logic                   unit_pulse;
  logic [NT-1:0]          time_elapsed;
  logic [1:0]             stall_dn;
  logic [NLO-1:0]         hb_data;
  logic                   hb_last;
  logic                   hb_valid;
  logic                   hb_ready = 1'b0;
  logic [1:0]             hb_drop_cnt;

  int total = 0;
  int bad   = 0;

  int       m_time, m_cnt, m_pcnt, m_drop;
  bit       m_pulse, m_beat;
  bit [1:0] m_stall;
  int       q[$];

  time_keeper #(
    .NUNIT(NUNIT), .NTIME_HI(NHI), .NTIME_LO(NLO),
    .NCHAN(2), .NDROP(2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .unit_len     (unit_len),
    .reset_time   (reset_time),
    .pc_time      (pc_time),
    .hb_period    (hb_period),
`ifdef TIME_KEEPER_PAUSE_EN
    .pause        (pause),
`endif
    .unit_pulse   (unit_pulse),
    .time_elapsed (time_elapsed),
    .stall_dn     (stall_dn),
    .hb_data      (hb_data),
    .hb_last      (hb_last),
    .hb_valid     (hb_valid),
    .hb_ready     (hb_ready),
    .hb_drop_cnt  (hb_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      if (bad <= 40)
        $display("FAIL %s: got %0h want %0h at %0t",
                 tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_time  = 1;
    m_cnt   = 0;
    m_pcnt  = 0;
    m_drop  = 0;
    m_pulse = 0;
    m_beat  = 0;
    m_stall = '0;
    q.delete();
  endtask

  // One clock edge of the reference, using inputs seen at it.
  task automatic model_edge();
    bit       trig;
    bit       valid;
    int       snap;
    int       len;
    bit [1:0] st;
    for (int i = 0; i < 2; i++)
      st[i] = int'(pc_time[i]) > m_time;
    valid = q.size() != 0;
    snap  = (m_time + 1) & TMASK;
    trig  = 0;
    if (reset_time || hb_period == 0) begin
      m_pcnt = 0;
    end else if (m_pulse) begin
      if (m_pcnt + 1 >= int'(hb_period)) begin
        trig   = 1;
        m_pcnt = 0;
      end else begin
        m_pcnt++;
      end
    end
    if (reset_time)
      while (q.size() > 1) void'(q.pop_back());
    if (valid && hb_ready) begin
      if (!m_beat) begin
        m_beat = 1;
      end else begin
        void'(q.pop_front());
        m_beat = 0;
      end
    end
    if (trig) begin
      if (q.size() < 2) begin
        q.push_back(snap);
      end else begin
        q[1] = snap;
        if (m_drop < DMAX) m_drop++;
      end
    end
    if (reset_time) m_time = 1;
    else if (m_pulse) m_time = snap;
    len = int'(unit_len);
    if (reset_time || len == 0) begin
      m_cnt   = 0;
      m_pulse = 0;
    end else if (m_cnt + 1 >= len) begin
      m_cnt   = 0;
      m_pulse = 1;
    end else begin
      m_cnt++;
      m_pulse = 0;
    end
    m_stall = st;
  endtask

  task automatic compare_all();
    int d;
    d = 0;
    if (q.size() != 0)
      d = m_beat ? (q[0] >> NLO) : (q[0] & LMASK);
    chk("pulse", 64'(unit_pulse), 64'(m_pulse));
    chk("time", 64'(time_elapsed), 64'(m_time));
    chk("stall", 64'(stall_dn), 64'(m_stall));
    chk("valid", 64'(hb_valid), 64'(q.size() != 0));
    chk("last", 64'(hb_last), 64'(q.size() != 0 && m_beat));
    chk("data", 64'(hb_data), 64'(d));
    chk("drop", 64'(hb_drop_cnt), 64'(m_drop));
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
    end
  endtask

  task automatic restart();
    reset_time = 1'b1;
    step(1);
    reset_time = 1'b0;
  endtask

  initial begin
    int waited;
    bit seen_hi;
    model_reset();
    #23;
    compare_all();
    @(negedge clk);
    reset = 1'b0;

    unit_len   = 8'd8;
    pc_time[0] = NT'(5);
    pc_time[1] = NT'(2);
    restart();
    step(40);

    hb_period = 6'd4;
    hb_ready  = 1'b1;
    restart();
    step(130);

    hb_ready = 1'b0;
    step(96);
    hb_ready = 1'b1;
    step(60);

    hb_ready  = 1'b0;
    unit_len  = 8'd1;
    hb_period = 6'd1;
    step(20);
    hb_ready  = 1'b1;
    step(20);

    for (int c = 0; c < 1500; c++) begin
      if (c % 50 == 0) begin
        unit_len  = NUNIT'($urandom_range(0, 4));
        hb_period = NLO'($urandom_range(0, 3));
      end
      if (c % 37 == 0) begin
        pc_time[0] = NT'($urandom_range(0, 300));
        pc_time[1] = NT'($urandom_range(0, 300));
      end
      hb_ready   = ($urandom % 4) != 0;
      reset_time = ($urandom % 100) == 0;
      step(1);
    end
    reset_time = 1'b0;

    hb_period = '0;
    hb_ready  = 1'b1;
    unit_len  = 8'd1;
    restart();
    step(1030);
    unit_len = '0;
    step(100);

    unit_len  = 8'd2;
    hb_period = 6'd2;
    hb_ready  = 1'b0;
    restart();
    waited = 0;
    while (q.size() == 0 && waited < 200) begin
      step(1);
      waited++;
    end
    chk("hb_wait", 64'(q.size() != 0), 64'(1));
    hb_ready = 1'b1;
    step(1);
    hb_ready = 1'b0;
    seen_hi = m_beat;
    chk("hi_beat", 64'(hb_last), 64'(seen_hi));
    reset_time = 1'b1;
    step(1);
    reset_time = 1'b0;
    chk("rt_hold", 64'(hb_valid), 64'(1));
    step(3);
    hb_ready = 1'b1;
    step(40);

    hb_period = 6'd1;
    unit_len  = 8'd1;
    hb_ready  = 1'b0;
    step(10);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_valid", 64'(hb_valid), 64'(0));
    chk("arst_time", 64'(time_elapsed), 64'(1));
    chk("arst_drop", 64'(hb_drop_cnt), 64'(0));
    chk("arst_stall", 64'(stall_dn), 64'(0));
    model_reset();
    @(negedge clk);
    reset    = 1'b0;
    hb_ready = 1'b1;
    step(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
